// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared definitions for the RV32I instruction encoder.
//   kind_e      : 4-bit instruction class carried on in_kind (10-15 are illegal)
//   OPC_*       : 7-bit major opcodes for each class
//   NOP_INSN    : canonical NOP (addi x0, x0, 0) emitted for illegal kinds
//   enc_word_t  : one FIFO entry, the encoded word plus its error flag
package rv32i_pkg;

  typedef enum logic [3:0] {
    K_LUI    = 4'd0,
    K_AUIPC  = 4'd1,
    K_JAL    = 4'd2,
    K_JALR   = 4'd3,
    K_BRANCH = 4'd4,
    K_LOAD   = 4'd5,
    K_STORE  = 4'd6,
    K_OP_IMM = 4'd7,
    K_OP     = 4'd8,
    K_FENCE  = 4'd9
  } kind_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] insn;
  } enc_word_t;

endpackage

// File: rtl/rv32i_encode_if.sv
// rv32i_encode_if -- field-bundle input handshake and encoded-word output
// handshake of the RV32I encoder.
//   in_*  : producer -> encoder (valid/ready), fields kind/funct3/funct7/rd/rs1/rs2/imm
//   out_* : encoder -> consumer (valid/ready), 32-bit instruction plus error flag
// modport master : the producer/consumer side (testbench or boot sequencer)
// modport slave  : the encoder itself
interface rv32i_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_insn, out_err
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_insn, out_err
  );
endinterface

// File: rtl/rv32i_encode_fifo.sv
// rv32i_encode_fifo -- DEPTH x WIDTH synchronous FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push,wdata : write one entry (caller guarantees !full)
//   pop        : drop the head entry (caller guarantees !empty)
//   rdata      : head entry, valid while !empty
//   full,empty : count == DEPTH / count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module rv32i_encode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an empty count masks stale contents and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/rv32i_encode.sv
// rv32i_encode -- streaming RV32I instruction encoder.
//   clk   : single rising-edge clock
//   rst_n : asynchronous active-low reset; empties the output FIFO
//   bus   : rv32i_encode_if.slave -- field bundle in (valid/ready),
//           encoded word + error flag out (valid/ready)
// Fields are packed combinationally and written into a DEPTH-entry FIFO on
// the accepting edge. Illegal kinds (10-15) produce a NOP with err set.
// Optional build macro RV32I_ENCODE_RANGE_CHECK_EN additionally flags
// immediates that do not fit their format (the word is still encoded from
// the truncated bits); without it only illegal kinds set err.
module rv32i_encode
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rv32i_encode_if.slave  bus
);
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift_op;
  logic [31:0] enc_insn;
  logic        illegal;
  logic        range_err;
  enc_word_t   wdata, rdata;
  logic        full, empty, push, pop;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;

  // Immediate shifts (slli/srli/srai) carry funct7 and a 5-bit shamt.
  assign shift_op = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    enc_insn = '0;
    illegal  = 1'b0;
    case (bus.in_kind)
      K_LUI:    enc_insn = {imm[31:12], rd, OPC_LUI};
      K_AUIPC:  enc_insn = {imm[31:12], rd, OPC_AUIPC};
      K_JAL:    enc_insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      K_JALR:   enc_insn = {imm[11:0], rs1, f3, rd, OPC_JALR};
      K_BRANCH: enc_insn = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      K_LOAD:   enc_insn = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      K_STORE:  enc_insn = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      K_OP_IMM: begin
        if (shift_op) enc_insn = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
        else          enc_insn = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
      end
      K_OP:     enc_insn = {f7, rs2, rs1, f3, rd, OPC_OP};
      K_FENCE:  enc_insn = {imm[11:0], rs1, f3, rd, OPC_FENCE};
      default: begin
        enc_insn = NOP_INSN;
        illegal  = 1'b1;
      end
    endcase
  end

`ifdef RV32I_ENCODE_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               i_ok, b_ok, j_ok;

  assign simm = $signed(imm);
  assign i_ok = (simm >= -32'sd2048)    && (simm <= 32'sd2047);
  assign b_ok = (simm >= -32'sd4096)    && (simm <= 32'sd4094)    && !imm[0];
  assign j_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];

  always_comb begin
    range_err = 1'b0;
    case (bus.in_kind)
      K_LUI, K_AUIPC:                   range_err = |imm[11:0];
      K_JAL:                            range_err = !j_ok;
      K_BRANCH:                         range_err = !b_ok;
      K_JALR, K_LOAD, K_STORE, K_FENCE: range_err = !i_ok;
      K_OP_IMM:                         range_err = shift_op ? (|imm[31:5]) : !i_ok;
      default:                          range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign wdata.insn = enc_insn;
  assign wdata.err  = illegal | range_err;

  // in_ready drops during reset as well as when full; no pass-through when full.
  assign bus.in_ready = rst_n & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~empty & bus.out_ready;

  rv32i_encode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(enc_word_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Outputs read as zero while empty so stale RAM contents never show.
  assign bus.out_valid = ~empty;
  assign bus.out_insn  = empty ? '0   : rdata.insn;
  assign bus.out_err   = empty ? 1'b0 : rdata.err;
endmodule

// File: tb/tb_rv32i_encode.sv
module tb_rv32i_encode;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_encode_if bus ();

  rv32i_encode #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef RV32I_ENCODE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the word from the field-placement rules with
  // plain shifts/masks on whole integers. Returns {err, insn}.
  function automatic logic [32:0] ref_enc(input int kind, input int f3, input int f7,
                                          input int rd, input int rs1, input int rs2,
                                          input logic [31:0] imm);
    logic [31:0] opc_tab [10];
    logic [31:0] w, rdf, f3f, rs1f, rs2f, f7f, ifield, sfield;
    int          si;
    bit          bad, ill;
    opc_tab = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03, 32'h23, 32'h13, 32'h33, 32'h0F};
    si   = int'(imm);
    rdf  = 32'(rd)  << 7;
    f3f  = 32'(f3)  << 12;
    rs1f = 32'(rs1) << 15;
    rs2f = 32'(rs2) << 20;
    f7f  = 32'(f7)  << 25;
    ifield = (imm & 32'hFFF) << 20;
    sfield = (((imm >> 5) & 32'h7F) << 25) + ((imm & 32'h1F) << 7);
    bad = 0; ill = 0; w = 0;
    case (kind)
      0, 1: begin
        w = opc_tab[kind] + rdf + (imm & 32'hFFFF_F000);
        bad = (imm & 32'hFFF) != 0;
      end
      2: begin
        w = opc_tab[kind] + rdf + (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3FF) << 21)
          + (((imm >> 11) & 1) << 20) + (imm & 32'h000F_F000);
        bad = si < -1048576 || si > 1048574 || (imm & 1) != 0;
      end
      3, 5, 9: begin
        w = opc_tab[kind] + rdf + f3f + rs1f + ifield;
        bad = si < -2048 || si > 2047;
      end
      4: begin
        w = opc_tab[kind] + f3f + rs1f + rs2f + (((imm >> 12) & 1) << 31)
          + (((imm >> 5) & 32'h3F) << 25) + (((imm >> 1) & 32'hF) << 8) + (((imm >> 11) & 1) << 7);
        bad = si < -4096 || si > 4094 || (imm & 1) != 0;
      end
      6: begin
        w = opc_tab[kind] + f3f + rs1f + rs2f + sfield;
        bad = si < -2048 || si > 2047;
      end
      7: begin
        if (f3 == 1 || f3 == 5) begin
          w = opc_tab[kind] + rdf + f3f + rs1f + ((imm & 32'h1F) << 20) + f7f;
          bad = imm > 31;
        end else begin
          w = opc_tab[kind] + rdf + f3f + rs1f + ifield;
          bad = si < -2048 || si > 2047;
        end
      end
      8: w = opc_tab[kind] + rdf + f3f + rs1f + rs2f + f7f;
      default: begin
        w = 32'h0000_0013;
        ill = 1;
      end
    endcase
    return {ill | (RC & bad), w};
  endfunction

  task automatic drive(input int kind, input int f3, input int f7, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
    bus.in_kind   = 4'(kind);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_imm    = imm;
  endtask

  // Offer one bundle; it is accepted at the first rising edge with in_ready high.
  task automatic send_one(input int kind, input int f3, input int f7, input int rd,
                          input int rs1, input int rs2, input logic [31:0] imm);
    int waited;
    @(negedge clk);
    drive(kind, f3, f7, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", {32'b0, bus.in_ready}, 33'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(ref_enc(kind, f3, f7, rd, rs1, rs2, imm));
    #1 bus.in_valid = 1'b0;
  endtask

  // Pop one word; compare with a literal (use_lit) or with the model queue.
  task automatic recv(input string tag, input bit use_lit, input logic [32:0] lit);
    int waited;
    logic [32:0] exp;
    @(negedge clk);
    bus.out_ready = 1'b1;
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, {32'b0, bus.out_valid}, 33'd1);
      bus.out_ready = 1'b0;
      return;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
    if (use_lit) exp = lit;
    check(tag, {bus.out_err, bus.out_insn}, exp);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [32:0] wa, wb, wc;
    logic [31:0] rimm;
    int k, mode;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0);

    // Reset state
    #1;
    check("rst_in_ready",  {32'b0, bus.in_ready},  33'd0);
    check("rst_out_valid", {32'b0, bus.out_valid}, 33'd0);
    check("rst_out_word",  {bus.out_err, bus.out_insn}, 33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {32'b0, bus.in_ready}, 33'd1);

    // ADDI x1, x0, 5 with one-cycle latency
    send_one(7, 0, 0, 1, 0, 0, 32'd5);
    #1;
    check("addi_latency_valid", {32'b0, bus.out_valid}, 33'd1);
    recv("addi", 1'b1, {1'b0, 32'h0050_0093});

    send_one(6, 2, 0, 0, 1, 2, 32'd8);
    recv("sw", 1'b1, {1'b0, 32'h0020_A423});
    send_one(0, 0, 0, 5, 0, 0, 32'h1234_5000);
    recv("lui", 1'b1, {1'b0, 32'h1234_52B7});
    send_one(4, 0, 0, 0, 1, 2, -32'sd4);
    recv("beq", 1'b1, {1'b0, 32'hFE20_8EE3});
    send_one(2, 0, 0, 1, 0, 0, 32'd2048);
    recv("jal", 1'b1, {1'b0, 32'h0010_00EF});
    send_one(7, 0, 0, 1, 0, 0, 32'd4096);
    recv("addi_4096", 1'b1, {RC, 32'h0000_0093});
    send_one(12, 3, 5, 7, 8, 9, 32'h1234);
    recv("illegal_kind12", 1'b1, {1'b1, 32'h0000_0013});
    send_one(7, 1, 7'h20, 3, 4, 0, 32'd40);
    recv("shift_oor", 1'b0, 33'd0);
    send_one(4, 1, 0, 0, 3, 4, 32'd4095);
    recv("branch_odd", 1'b0, 33'd0);

    // Backpressure: fill DEPTH=2, third word held until space frees
    send_one(7, 0, 0, 1, 0, 0, 32'd11);
    send_one(8, 0, 7'h20, 2, 3, 4, 32'd0);
    wa = exp_q.pop_front();
    wb = exp_q.pop_front();
    wc = ref_enc(5, 2, 0, 6, 7, 0, 32'd100);
    @(negedge clk);
    check("full_in_ready", {32'b0, bus.in_ready}, 33'd0);
    check("full_head", {bus.out_err, bus.out_insn}, wa);
    drive(5, 2, 0, 6, 7, 0, 32'd100);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("held_in_ready", {32'b0, bus.in_ready}, 33'd0);
    check("held_head", {bus.out_err, bus.out_insn}, wa);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("drain_b", {bus.out_err, bus.out_insn}, wb);
    check("drain_in_ready", {32'b0, bus.in_ready}, 33'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain_c", {bus.out_err, bus.out_insn}, wc);
    @(negedge clk);
    check("drain_empty", {32'b0, bus.out_valid}, 33'd0);
    bus.out_ready = 1'b0;

    // Reset mid-stream with two words queued
    send_one(7, 0, 0, 1, 0, 0, 32'd1);
    send_one(7, 0, 0, 2, 0, 0, 32'd2);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {32'b0, bus.out_valid}, 33'd0);
    check("midrst_in_ready",  {32'b0, bus.in_ready},  33'd0);
    check("midrst_out_word",  {bus.out_err, bus.out_insn}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", {32'b0, bus.in_ready}, 33'd1);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_stale", {32'b0, bus.out_valid}, 33'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;

    // Randomized stream against the reference model
    for (int i = 0; i < 60; i++) begin
      k    = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       rimm = $urandom;
        2:       rimm = 32'($urandom_range(0, 31));
        default: rimm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      send_one(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), rimm);
      if ($urandom_range(0, 1) == 1) begin
        send_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom);
        recv("rand", 1'b0, 33'd0);
      end
      recv("rand", 1'b0, 33'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32i_encode.md
Name: rv32i_encode

Overview:
Streaming RV32I instruction encoder, the inverse of the opcode-class decoder. It accepts instruction fields (class, funct, registers, immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. Each word is queued in a small FIFO and emitted over a second valid/ready handshake. It sits in the boot/self-test path, generating instruction streams for the core's fetch/decode input.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, >=2).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  field bundle valid.
in_ready  out  1  encoder can accept; low while FIFO full or rst_n low.
in_kind  in  4  class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE; 10-15 illegal.
in_funct3  in  3  funct3 field.
in_funct7  in  7  funct7 field (OP, OP_IMM shifts).
in_rd  in  5  destination register.
in_rs1  in  5  source 1.
in_rs2  in  5  source 2.
in_imm  in  32  byte-offset/immediate, two's complement.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_insn  out  32  encoded instruction.
out_err  out  1  head word flagged illegal/out-of-range.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: FIFO emptied, pointers and count = 0. out_valid=0, out_insn=0, out_err=0, in_ready=0 while rst_n low. In-flight words are discarded on reset mid-stream.
- Accept on in_valid & in_ready. Encoding is combinational, and the word is written to the FIFO the same edge. Latency: a word accepted at edge N is presented at out_valid after edge N (next cycle) when the FIFO was empty.
- Pop on out_valid & out_ready. out_insn/out_err are held stable while out_valid & !out_ready.
- in_ready = !full, with no same-cycle pass-through when full. Push and pop in the same cycle (not full) leave the count unchanged.
- Pointers wrap modulo DEPTH. full when count==DEPTH; out_valid = count!=0.
- Opcodes: LUI 0x37, AUIPC 0x17, JAL 0x6F, JALR 0x67, BRANCH 0x63, LOAD 0x03, STORE 0x23, OP_IMM 0x13, OP 0x33, FENCE 0x0F.
- Field placement: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- U-type: imm[31:12] -> [31:12].
- I-type (JALR, LOAD, OP_IMM, FENCE): imm[11:0] -> [31:20].
- OP_IMM with funct3 001/101: [31:25]=funct7, [24:20]=imm[4:0].
- S-type: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
- B-type: imm[12] -> 31, imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> 7.
- J-type: imm[20] -> 31, imm[10:1] -> [30:21], imm[11] -> 20, imm[19:12] -> [19:12].
- Fields not used by a type are forced to 0. Unused rd/rs/funct inputs are ignored.
- Illegal kind (10-15): word = 0x00000013 (NOP), err=1, regardless of macro.

Optional Feature:
RV32I_ENCODE_RANGE_CHECK_EN. When defined, err=1 (word still encoded from truncated bits) when any of these hold:
- I/S immediate outside [-2048, 2047].
- B immediate outside [-4096, 4094] or imm[0]=1.
- J immediate outside [-1048576, 1048574] or imm[0]=1.
- U imm[11:0]!=0.
- Shift imm[31:5]!=0.
When undefined, no checks are made, err comes only from an illegal kind, and the immediate is silently truncated.

Decomposition:
- Package rv32i_pkg: 7-bit opcode constants, 4-bit kind enum, NOP constant 0x00000013.
- Sub-module rv32i_encode_fifo (DEPTH x 33-bit sync FIFO with count, full/empty).
- Encode/check logic stays in the top.

Test Plan:
- ADDI: kind=7, funct3=0, rd=1, rs1=0, imm=5 -> out_insn=0x00500093, err=0, out_valid one cycle after accept.
- SW: kind=6, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. LUI: kind=0, rd=5, imm=0x12345000 -> 0x123452B7.
- BEQ: kind=4, funct3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. JAL: kind=2, rd=1, imm=2048 -> 0x001000EF.
- ADDI with imm=4096: with macro -> err=1, insn=0x00000093; without macro -> err=0, same insn. kind=12 -> 0x00000013, err=1.
- out_ready=0, DEPTH=2, push 3 words -> in_ready falls after 2nd accept and the 3rd is held. Release out_ready -> words emerge in order, then the 3rd is accepted.
- Assert rst_n low with 2 words queued -> out_valid=0 immediately. After release, in_ready=1, no stale words emitted.
